// File: rtl/dmem_io_if.sv
// rtl/dmem_io_if.sv - core-to-data-memory bus bundle
interface dmem_io_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;

    // Core side drives address/data/enables and consumes read data
    modport master (
        output dmemaddr,
        output dmemwdata,
        output dmemwrite,
        output dmemread,
        input  dmemrdata
    );

    // Memory/IO side consumes the request and returns read data
    modport slave (
        input  dmemaddr,
        input  dmemwdata,
        input  dmemwrite,
        input  dmemread,
        output dmemrdata
    );
endinterface

// File: rtl/dmem_io.sv
// rtl/dmem_io.sv - data RAM plus board I/O register page for the PMIPS MEM stage
module dmem_io #(
    parameter int          RAM_AW  = 8,
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic            clock,
    input  logic            reset,
    dmem_io_if.slave        bus,
    input  logic [7:0]      switches,
    input  logic [3:0]      buttons,
    output logic [7:0]      leds,
    output logic [15:0]     hexval,
    output logic            timer_irq
);

    localparam int RAM_WORDS = 1 << RAM_AW;

    // Register slots within the I/O page, indexed by halfword offset
    localparam logic [2:0] REG_LED     = 3'd0;
    localparam logic [2:0] REG_HEX     = 3'd1;
    localparam logic [2:0] REG_SW      = 3'd2;
    localparam logic [2:0] REG_BTN     = 3'd3;
    localparam logic [2:0] REG_BTNEDGE = 3'd4;
    localparam logic [2:0] REG_CYCLE   = 3'd5;
    localparam logic [2:0] REG_TIMER   = 3'd6;
    localparam logic [2:0] REG_STATUS  = 3'd7;

    logic [15:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;

    logic              io_sel;
    logic [14:0]       io_word;
    logic              io_hit;
    logic [2:0]        reg_idx;
    logic [7:0]        reg_wr;
    logic              wr_ram;

    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    logic [3:0]        btn_meta;
    logic [3:0]        btn_sync;
    logic [3:0]        btn_prev;
    logic [3:0]        btn_rise;
    logic [3:0]        btn_edge;
    logic [3:0]        edge_clr;

    logic [15:0]       cycle_cnt;
    logic [15:0]       timer_cnt;
    logic              tflag;
    logic              timer_expire;

    logic [15:0]       rdata;

    // Address decode: RAM below IO_BASE (upper bits alias), 8 halfword registers at the page start
    assign ram_idx = bus.dmemaddr[RAM_AW:1];
    assign io_sel  = (bus.dmemaddr >= IO_BASE);
    assign io_word = bus.dmemaddr[15:1] - IO_BASE[15:1];
    assign io_hit  = io_sel && (io_word[14:3] == 12'h000);
    assign reg_idx = io_word[2:0];
    assign wr_ram  = bus.dmemwrite && !io_sel;

    // One-hot register write strobes; unmapped page addresses produce none
    always_comb begin
        reg_wr = '0;
        if (bus.dmemwrite && io_hit) begin
            reg_wr[reg_idx] = 1'b1;
        end
    end

    // Word RAM: synchronous write, contents survive reset, writes held off while in reset
    always_ff @(posedge clock) begin
        if (reset && wr_ram) begin
            ram[ram_idx] <= bus.dmemwdata;
        end
    end

    // Two-flop synchronisers for the board inputs, plus the delayed copy used for edge detect
    always_ff @(posedge clock) begin
        if (!reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            btn_meta <= buttons;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // LED and hex display registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            leds   <= '0;
            hexval <= '0;
        end else begin
            if (reg_wr[REG_LED]) begin
                leds <= bus.dmemwdata[7:0];
            end
            if (reg_wr[REG_HEX]) begin
                hexval <= bus.dmemwdata;
            end
        end
    end

    assign btn_rise = btn_sync & ~btn_prev;
    assign edge_clr = reg_wr[REG_BTNEDGE] ? bus.dmemwdata[3:0] : 4'h0;

    // Sticky button-edge flags: a fresh rising edge wins over a same-cycle write-1-to-clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_edge <= '0;
        end else begin
            btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
        end
    end

    // Free-running cycle counter; a write load takes the place of the increment
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (reg_wr[REG_CYCLE]) begin
            cycle_cnt <= bus.dmemwdata;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    // Only a genuine countdown step from 1 raises the flag; a load (even of 0) never does
    assign timer_expire = !reg_wr[REG_TIMER] && (timer_cnt == 16'd1);

    // Down-counting timer that parks at zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_cnt <= '0;
        end else if (reg_wr[REG_TIMER]) begin
            timer_cnt <= bus.dmemwdata;
        end else if (timer_cnt != 16'd0) begin
            timer_cnt <= timer_cnt - 16'd1;
        end
    end

    // Timer flag: expiry wins over a same-cycle write-1-to-clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            tflag <= 1'b0;
        end else if (timer_expire) begin
            tflag <= 1'b1;
        end else if (reg_wr[REG_STATUS] && bus.dmemwdata[0]) begin
            tflag <= 1'b0;
        end
    end

    assign timer_irq = tflag;

    // Combinational read mux; shows pre-write state so a same-cycle write appears next cycle
    always_comb begin
        rdata = '0;
        if (bus.dmemread) begin
            if (!io_sel) begin
                rdata = ram[ram_idx];
            end else if (io_hit) begin
                case (reg_idx)
                    REG_LED:     rdata = {8'h00, leds};
                    REG_HEX:     rdata = hexval;
                    REG_SW:      rdata = {8'h00, sw_sync};
                    REG_BTN:     rdata = {12'h000, btn_sync};
                    REG_BTNEDGE: rdata = {12'h000, btn_edge};
                    REG_CYCLE:   rdata = cycle_cnt;
                    REG_TIMER:   rdata = timer_cnt;
                    REG_STATUS:  rdata = {15'h0000, tflag};
                    default:     rdata = '0;
                endcase
            end
        end
    end

    assign bus.dmemrdata = rdata;

endmodule

// File: doc/dmem_io.md
# dmem_io

Data-memory and memory-mapped I/O stage downstream of the pipelined PMIPS core's MEM stage. It consumes `dmemaddr`/`dmemwdata`/`dmemwrite`/`dmemread` and returns `dmemrdata` in the same cycle, so the core's MEM/WB register captures it on the next rising edge. It holds a word RAM plus a small I/O register page for the Spartan-3E board:

- LEDs and hex display value
- synchronised switches and buttons with sticky button-edge flags
- free-running cycle counter
- down-counting timer with a sticky flag

## Interface
- `RAM_AW`, default 8: RAM depth is 2^RAM_AW 16-bit words.
- `IO_BASE`, default 16'hFF00: base of the I/O page. Addresses ≥ `IO_BASE` are I/O; everything below is RAM.
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-low (0 = reset), sampled on the rising edge of `clock`.
- `dmemaddr`  in  16  Byte address from the core; bit 0 ignored.
- `dmemwdata`  in  16  Write data.
- `dmemwrite`  in  1  Write enable.
- `dmemread`  in  1  Read enable.
- `dmemrdata`  out  16  Read data, combinational.
- `switches`  in  8  Asynchronous board switches.
- `buttons`  in  4  Asynchronous board buttons.
- `leds`  out  8  LED register.
- `hexval`  out  16  Seven-segment display value register.
- `timer_irq`  out  1  Equals the timer flag `TFLAG`.

## Operation
- **RAM decode:** an address below `IO_BASE` selects word `dmemaddr[RAM_AW:1]`; higher address bits alias.
  - Write: synchronous, on an edge with `dmemwrite`=1.
  - Read: asynchronous.
  - RAM is not cleared by reset.
- **I/O offsets** (`dmemaddr[3:0]` within the page; other page addresses read 0 and ignore writes):
  - 0x0 LED: R/W, low 8 bits; reads `{8'b0, leds}`.
  - 0x2 HEX: R/W, 16 bits.
  - 0x4 SW: read-only, `{8'b0, sw_sync}`.
  - 0x6 BTN: read-only, `{12'b0, btn_sync}`.
  - 0x8 BTNEDGE: 4 sticky flags, one per button, set on a `btn_sync` rising edge. Write-1-to-clear.
  - 0xA CYCLE: 16-bit counter, +1 every cycle, wraps 0xFFFF→0x0000. A write loads `dmemwdata`.
  - 0xC TIMER: a write loads the count. When nonzero, decrements by 1 per cycle. On the 1→0 transition `TFLAG` is set. Stays at 0.
  - 0xE STATUS: bit0 = `TFLAG`. Write-1-to-clear; bits 15:1 read 0.
- **Read-enable gating:** `dmemrdata` = 0 whenever `dmemread`=0.
- **Input synchronisation:** `switches` and `buttons` each pass through a 2-flop synchroniser.
  - `btn_sync` edges are detected against a registered `btn_prev`.
- **Simultaneous events** (priorities are fixed):
  - Edge set beats W1C clear on the same BTNEDGE bit.
  - Timer 1→0 set beats W1C clear of `TFLAG`.
  - Write load beats increment (CYCLE) and decrement (TIMER).
- **Read-during-write:** with `dmemread` and `dmemwrite` both 1 to the same location, `dmemrdata` shows the old value. The new value is visible from the next cycle.
- **Reset** (`reset`=0 at an edge) clears all of: `leds`, `hexval`, CYCLE, TIMER, `TFLAG`, BTNEDGE, all synchroniser flops, `btn_prev`.
  - Reset overrides any concurrent write or count.
  - Reset asserted mid-countdown zeroes TIMER without setting `TFLAG`.

## Timing
- Read latency 0 cycles (combinational from address/enable). Write latency 1 edge.
- Switch change to SW-visible: 2 rising edges.
- Button press to BTNEDGE flag set: 3 rising edges (2 synchroniser + edge register).
- TIMER written with N ≥ 1 at edge k: `TFLAG` = 1 after edge k+N; `timer_irq` is high from then on.
  - Writing 0 stops the timer with no flag.
- CYCLE reads value C at edge k, C+1 at edge k+1. CYCLE written with V at edge k reads V after edge k, V+1 after edge k+1.
- All outputs except `dmemrdata` are registered. Values after reset: `leds`=0, `hexval`=0, `timer_irq`=0. `dmemrdata`=0 while `dmemread`=0.

## Test plan
- **RAM:** hold `reset`=0 for 2 cycles, release. Write 0xBEEF to addr 0x0010, then read 0x0010 and 0x0011 → 0xBEEF both. Read 0x0010 with `dmemread`=0 → 0x0000. Same-cycle read/write of 0x1234 to 0x0010 → returns 0xBEEF, then 0x1234.
- **LED/HEX/reset:** write 0x01A5 to 0xFF00 → `leds`=0xA5, read 0x00A5. Write 0xCAFE to 0xFF02 → `hexval`=0xCAFE. Assert reset → both 0 after the edge.
- **Switches/buttons:** drive `switches`=0x3C → SW reads 0x3C only after 2 edges. Pulse `buttons[2]` high → BTNEDGE=0x4 after 3 edges and held after release. W1C 0x4 → 0. Edge coinciding with W1C → stays 1.
- **Timer:** write 5 to 0xFF0C → `timer_irq` rises exactly 5 edges later and TIMER reads 0. W1C STATUS → `timer_irq`=0. Reload 3 then reset at the 2nd edge → TIMER=0, no flag.
- **Cycle counter:** write 0xFFFE to 0xFF0A → reads 0xFFFE, 0xFFFF, 0x0000 on successive cycles.
- **Unmapped I/O:** write 0x1234 to 0xFF20 → reads 0, and no other register changes.
